// File: rtl/sample_out.sv
// sample_out: gain scaling on the shared multiplier, 16-bit saturation and I2S serialiser.
// Define SAMPLE_OUT_CLIP_EN to build the sticky clip flag; otherwise clip is tied low.
`timescale 1ns/1ps
module sample_out #(
   parameter int unsigned CLK_DIV = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        finish,
   input  logic [63:0] mult_p,
   output logic [31:0] mult_a,
   output logic [31:0] mult_b,
   input  logic [31:0] x,
   input  logic [31:0] gain,
   output logic        sample_req,
   output logic        bclk,
   output logic        lrck,
   output logic        sdata,
   output logic        clip
);
   localparam int unsigned    DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_BUBBLE  = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_FINISH  = 2'd3;

   logic [1:0]       r_state;
   logic [15:0]      r_hold;
   logic [DIV_W-1:0] r_div;
   logic             r_bclk;
   logic             r_lrck;
   logic             r_sdata;
   logic             r_sample_req;
   logic [4:0]       r_bit;
   logic [31:0]      r_shreg;

   logic             w_tick;
   logic             w_ovf;
   logic [15:0]      w_sat;
   logic             w_unused_lsbs;

   // Result window p[48:33] is exact only when everything above its sign bit matches it.
   always_comb begin
      w_ovf = ~((&mult_p[63:48]) | ~(|mult_p[63:48]));
      if (!w_ovf) begin
         w_sat = mult_p[48:33];
      end else if (mult_p[63]) begin
         w_sat = 16'h8000;
      end else begin
         w_sat = 16'h7FFF;
      end
   end

   assign w_unused_lsbs = ^mult_p[32:0];

   assign mult_a = (r_state == S_IDLE) ? gain : '0;
   assign mult_b = (r_state == S_IDLE) ? x    : '0;
   assign finish = (r_state == S_FINISH);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_hold  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_BUBBLE;
               end
            end
            S_BUBBLE: begin
               r_state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               r_hold  <= w_sat;
               r_state <= S_FINISH;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef SAMPLE_OUT_CLIP_EN
   logic r_clip;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_clip <= 1'b0;
      end else if ((r_state == S_CAPTURE) && w_ovf) begin
         r_clip <= 1'b1;
      end
   end

   assign clip = r_clip;
`else
   assign clip = 1'b0;
`endif

   assign w_tick = (r_div == DIV_LAST);

   // r_bit is the index of the bclk period that the next falling edge begins; bit 0 opens a frame.
   // The right-channel LSB leaves on bclk 0 of the following frame, so it is sent before the reload.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div        <= '0;
         r_bclk       <= 1'b0;
         r_bit        <= '0;
         r_lrck       <= 1'b0;
         r_sdata      <= 1'b0;
         r_shreg      <= '0;
         r_sample_req <= 1'b0;
      end else begin
         r_sample_req <= 1'b0;
         if (w_tick) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
            if (r_bclk) begin
               r_bit   <= r_bit + 5'd1;
               r_lrck  <= r_bit[4];
               r_sdata <= r_shreg[31];
               if (r_bit == '0) begin
                  r_shreg      <= {r_hold, r_hold};
                  r_sample_req <= 1'b1;
               end else begin
                  r_shreg <= {r_shreg[30:0], 1'b0};
               end
            end
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
      end
   end

   assign bclk       = r_bclk;
   assign lrck       = r_lrck;
   assign sdata      = r_sdata;
   assign sample_req = r_sample_req;

endmodule

// File: tb/tb_sample_out.sv
// Directed bench for sample_out: handshake timing, saturation, I2S framing and reset behaviour.
// Behaves as the shared two-stage multiplier; expected clip follows SAMPLE_OUT_CLIP_EN.
`timescale 1ns/1ps
module tb_sample_out;
   localparam int CLK_DIV = 4;
   localparam int FRAME   = 64 * CLK_DIV;
`ifdef SAMPLE_OUT_CLIP_EN
   localparam logic CLIP_EXP = 1'b1;
`else
   localparam logic CLIP_EXP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        finish;
   logic [63:0] mult_p;
   logic [31:0] mult_a;
   logic [31:0] mult_b;
   logic [31:0] x;
   logic [31:0] gain;
   logic        sample_req;
   logic        bclk;
   logic        lrck;
   logic        sdata;
   logic        clip;

   logic [63:0] r_p1 = '0;
   logic [63:0] r_p2 = '0;

   int n_tests = 0;
   int n_fail  = 0;

   sample_out #(.CLK_DIV(CLK_DIV)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .finish     (finish),
      .mult_p     (mult_p),
      .mult_a     (mult_a),
      .mult_b     (mult_b),
      .x          (x),
      .gain       (gain),
      .sample_req (sample_req),
      .bclk       (bclk),
      .lrck       (lrck),
      .sdata      (sdata),
      .clip       (clip)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      r_p1 <= {{32{mult_a[31]}}, mult_a} * {{32{mult_b[31]}}, mult_b};
      r_p2 <= r_p1;
   end
   assign mult_p = r_p2;

   task automatic wait_frame(output bit ok);
      int i;
      ok = 1'b0;
      i  = 0;
      while (!ok && i < FRAME + 16) begin
         @(negedge clk);
         i++;
         if (sample_req === 1'b1) ok = 1'b1;
      end
   endtask

   // Samples the middle of bclk 1..32 (bclk 32 = next frame's bclk 0), counting lrck errors.
   task automatic capture_bits(input int first_wait, output logic [15:0] left,
                               output logic [15:0] right, output int lrck_err);
      left     = '0;
      right    = '0;
      lrck_err = 0;
      repeat (first_wait) @(negedge clk);
      for (int i = 1; i <= 32; i++) begin
         repeat (2 * CLK_DIV) @(negedge clk);
         if (i <= 16) left  = {left[14:0], sdata};
         else         right = {right[14:0], sdata};
         if (lrck !== 1'((i % 32) >= 16)) lrck_err++;
      end
   endtask

   task automatic do_start(input logic [31:0] xv, input logic [31:0] gv, input int hold,
                           output logic [63:0] ops0, output logic [63:0] ops1,
                           output logic [5:0] fpat);
      x     = xv;
      gain  = gv;
      start = 1'b1;
      #1;
      ops0 = {mult_a, mult_b};
      ops1 = '0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) ops1 = {mult_a, mult_b};
         fpat[6-k] = finish;
         if (k >= hold) start = 1'b0;
         else           x = ~xv;
      end
   endtask

   task automatic test_reset();
      int          cnt;
      logic [15:0] l;
      logic [15:0] r;
      int          le;
      rst = 1'b1; start = 1'b0; x = '0; gain = '0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({finish, sample_req, bclk, lrck, sdata, clip} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected 000000", {finish, sample_req, bclk, lrck, sdata, clip});
      end
      rst = 1'b0;
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (sample_req !== 1'b1 && cnt < FRAME + 16);
      n_tests++;
      if (cnt !== 2 * CLK_DIV) begin
         n_fail++;
         $display("FAIL first_req: got %0d cycles expected %0d", cnt, 2 * CLK_DIV);
      end
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (sample_req !== 1'b1 && cnt < FRAME + 16);
      n_tests++;
      if (cnt !== FRAME) begin
         n_fail++;
         $display("FAIL req_period: got %0d cycles expected %0d", cnt, FRAME);
      end
      capture_bits(CLK_DIV, l, r, le);
      n_tests++;
      if (l !== 16'h0000) begin n_fail++; $display("FAIL idle_left: got %h expected 0000", l); end
      n_tests++;
      if (r !== 16'h0000) begin n_fail++; $display("FAIL idle_right: got %h expected 0000", r); end
      n_tests++;
      if (le !== 0) begin n_fail++; $display("FAIL idle_lrck: got %0d errors expected 0", le); end
   endtask

   task automatic test_scale();
      bit          ok;
      logic [63:0] o0;
      logic [63:0] o1;
      logic [5:0]  fp;
      logic [15:0] l;
      logic [15:0] r;
      int          le;
      wait_frame(ok);
      repeat (10) @(negedge clk);
      // start held a second cycle with a different x; that cycle falls outside IDLE
      do_start(32'h0080_0000, 32'h0100_0000, 2, o0, o1, fp);
      n_tests++;
      if (o0 !== 64'h0100_0000_0080_0000) begin n_fail++; $display("FAIL idle_operands: got %h expected 0100000000800000", o0); end
      n_tests++;
      if (o1 !== 64'h0) begin n_fail++; $display("FAIL busy_operands: got %h expected 0", o1); end
      n_tests++;
      if (fp !== 6'b001000) begin n_fail++; $display("FAIL finish_timing: got %b expected 001000", fp); end
      wait_frame(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL scale_frame: got timeout expected sample_req"); end
      capture_bits(CLK_DIV, l, r, le);
      n_tests++;
      if (l !== 16'h4000) begin n_fail++; $display("FAIL scale_left: got %h expected 4000", l); end
      n_tests++;
      if (r !== 16'h4000) begin n_fail++; $display("FAIL scale_right: got %h expected 4000", r); end
      n_tests++;
      if (le !== 0) begin n_fail++; $display("FAIL scale_lrck: got %0d errors expected 0", le); end
      n_tests++;
      if (clip !== 1'b0) begin n_fail++; $display("FAIL scale_clip: got %b expected 0", clip); end
   endtask

   task automatic test_saturation();
      logic [31:0] tx [3] = '{32'hFF00_0000, 32'h0100_0000, 32'hFE00_0000};
      logic [31:0] tg [3] = '{32'h0100_0000, 32'h0200_0000, 32'h0100_0000};
      logic [15:0] te [3] = '{16'h8000, 16'h7FFF, 16'h8000};
      logic        tc [3] = '{1'b0, CLIP_EXP, CLIP_EXP};
      bit          ok;
      logic [63:0] o0;
      logic [63:0] o1;
      logic [5:0]  fp;
      logic [15:0] l;
      logic [15:0] r;
      int          le;
      for (int v = 0; v < 3; v++) begin
         wait_frame(ok);
         repeat (10) @(negedge clk);
         do_start(tx[v], tg[v], 1, o0, o1, fp);
         n_tests++;
         if (fp !== 6'b001000) begin n_fail++; $display("FAIL sat%0d_finish: got %b expected 001000", v, fp); end
         wait_frame(ok);
         n_tests++;
         if (!ok) begin n_fail++; $display("FAIL sat%0d_frame: got timeout expected sample_req", v); end
         capture_bits(CLK_DIV, l, r, le);
         n_tests++;
         if (l !== te[v]) begin n_fail++; $display("FAIL sat%0d_left: got %h expected %h", v, l, te[v]); end
         n_tests++;
         if (r !== te[v]) begin n_fail++; $display("FAIL sat%0d_right: got %h expected %h", v, r, te[v]); end
         n_tests++;
         if (clip !== tc[v]) begin n_fail++; $display("FAIL sat%0d_clip: got %b expected %b", v, clip, tc[v]); end
      end
   endtask

   task automatic test_frame_collision();
      bit          ok;
      logic [15:0] l;
      logic [15:0] r;
      int          le;
      wait_frame(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL coll_sync: got timeout expected sample_req"); end
      // start lands so that the CAPTURE write shares its clock edge with the next frame load
      repeat (FRAME - 3) @(negedge clk);
      x = 32'h0040_0000; gain = 32'h0100_0000; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (sample_req !== 1'b1) begin n_fail++; $display("FAIL coll_req: got %b expected 1", sample_req); end
      capture_bits(CLK_DIV, l, r, le);
      n_tests++;
      if ({l, r} !== {16'h8000, 16'h8000}) begin n_fail++; $display("FAIL coll_old: got %h %h expected 8000 8000", l, r); end
      capture_bits(0, l, r, le);
      n_tests++;
      if ({l, r} !== {16'h2000, 16'h2000}) begin n_fail++; $display("FAIL coll_new: got %h %h expected 2000 2000", l, r); end
      n_tests++;
      if (le !== 0) begin n_fail++; $display("FAIL coll_lrck: got %0d errors expected 0", le); end
   endtask

   task automatic test_reset_midword();
      int          cnt;
      logic [15:0] l;
      logic [15:0] r;
      int          le;
      // now mid bclk 0 of a frame carrying 0x2000; advance to mid bclk 19 (right bit 13 = 1)
      repeat (19 * 2 * CLK_DIV) @(negedge clk);
      n_tests++;
      if ({bclk, lrck, sdata} !== 3'b111) begin n_fail++; $display("FAIL pre_reset: got %b expected 111", {bclk, lrck, sdata}); end
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({bclk, lrck, sdata, sample_req, finish, clip} !== 6'b0) begin
         n_fail++;
         $display("FAIL midword_reset: got %b expected 000000", {bclk, lrck, sdata, sample_req, finish, clip});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (sample_req !== 1'b1 && cnt < FRAME + 16);
      n_tests++;
      if (cnt !== 2 * CLK_DIV) begin n_fail++; $display("FAIL restart_req: got %0d cycles expected %0d", cnt, 2 * CLK_DIV); end
      capture_bits(CLK_DIV, l, r, le);
      n_tests++;
      if ({l, r} !== 32'h0) begin n_fail++; $display("FAIL restart_data: got %h %h expected 0000 0000", l, r); end
      n_tests++;
      if (le !== 0) begin n_fail++; $display("FAIL restart_lrck: got %0d errors expected 0", le); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; x = '0; gain = '0;
      test_reset();
      test_scale();
      test_saturation();
      test_frame_collision();
      test_reset_midword();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
